cu_program_sequencer: RTL and testbench

//  Instruction source for the compute unit. Stores a short program loaded byte-wise from the host.
//  On start, issues the program one 16-bit instruction per cycle onto the compute unit's {ui_in,uio_in} bus.

---
 rtl/cu_program_sequencer_if.sv | 32 +++
 rtl/cu_program_sequencer.sv | 159 +++++++++++++++
 tb/tb_cu_program_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_program_sequencer_if.sv
// Host / compute-unit signal bundle for cu_program_sequencer.
// The slave modport is the sequencer; the master is the host plus the compute unit.
interface cu_program_sequencer_if #(
  parameter int AW = 4
);
  logic          clear;
  logic          wr_valid;
  logic [7:0]    wr_byte;
  logic          wr_ready;
  logic          start;
  logic [15:0]   instr;
  logic          instr_valid;
  logic [7:0]    result;
  logic          res_valid;
  logic [7:0]    res_data;
  logic [AW-1:0] res_idx;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;

  modport master (
    output clear, wr_valid, wr_byte, start, result,
    input  wr_ready, instr, instr_valid, res_valid, res_data, res_idx,
           prog_len, busy, done
  );

  modport slave (
    input  clear, wr_valid, wr_byte, start, result,
    output wr_ready, instr, instr_valid, res_valid, res_data, res_idx,
           prog_len, busy, done
  );
endinterface

// File: rtl/cu_program_sequencer.sv
// Program store loaded byte-wise by the host, replayed one 16-bit word per cycle
// to the compute unit, with each returned result tagged by its program index.
module cu_program_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int RES_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  cu_program_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW:0]          prog_len_q, prog_len_d;
  logic                 half_q, half_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [7:0]           hi_q, hi_d;
  logic [1:0]           drain_cnt_q, drain_cnt_d;
  logic [RES_LAT-1:0]   vld_p_q, vld_p_d;
  logic [AW-1:0]        idx_p_q [RES_LAT];
  logic [AW-1:0]        idx_p_d [RES_LAT];
  logic                 res_valid_q, res_valid_d;
  logic [7:0]           res_data_q, res_data_d;
  logic [AW-1:0]        res_idx_q, res_idx_d;
  logic [15:0]          mem_q [DEPTH];
  logic                 mem_we;
  logic                 issue;
  logic                 wr_ready;

  assign issue    = (state_q == ST_ISSUE);
  assign wr_ready = (state_q == ST_IDLE) && (prog_len_q != (AW+1)'(DEPTH));

  assign bus.wr_ready    = wr_ready;
  assign bus.instr       = issue ? mem_q[rptr_q] : 16'h0000;
  assign bus.instr_valid = issue;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_idx     = res_idx_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);

  always_comb begin
    state_d     = state_q;
    prog_len_d  = prog_len_q;
    half_d      = half_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    hi_d        = hi_q;
    drain_cnt_d = drain_cnt_q;
    vld_p_d     = vld_p_q;
    idx_p_d     = idx_p_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    mem_we      = 1'b0;

    if (ena) begin
      // Result delay line: slot 0 tags the word on the bus, the last slot lines up with 'result'
      vld_p_d[0] = issue;
      idx_p_d[0] = rptr_q;
      for (int i = 1; i < RES_LAT; i++) begin
        vld_p_d[i] = vld_p_q[i-1];
        idx_p_d[i] = idx_p_q[i-1];
      end
      res_valid_d = vld_p_q[RES_LAT-1];
      if (vld_p_q[RES_LAT-1]) begin
        res_data_d = bus.result;
        res_idx_d  = idx_p_q[RES_LAT-1];
      end

      unique case (state_q)
        ST_IDLE: begin
          if (bus.clear) begin
            prog_len_d = '0;
            wptr_d     = '0;
            half_d     = 1'b0;
          end else if (bus.start && (prog_len_q != '0) && !half_q) begin
            rptr_d  = '0;
            state_d = ST_ISSUE;
          end else if (bus.wr_valid && wr_ready) begin
            if (!half_q) begin
              hi_d   = bus.wr_byte;
              half_d = 1'b1;
            end else begin
              mem_we     = 1'b1;
              wptr_d     = wptr_q + 1'b1;
              prog_len_d = prog_len_q + 1'b1;
              half_d     = 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          rptr_d = rptr_q + 1'b1;
          if ({1'b0, rptr_q} == prog_len_q - 1'b1) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
        ST_DRAIN: begin
          // Hold off DONE until the last issued word has left the delay line
          if (drain_cnt_q == 2'(RES_LAT - 1)) begin
            state_d = ST_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prog_len_q  <= '0;
      half_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      drain_cnt_q <= '0;
      vld_p_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      prog_len_q  <= prog_len_d;
      half_q      <= half_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      drain_cnt_q <= drain_cnt_d;
      vld_p_q     <= vld_p_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
    end
  end

  // Data-only registers: meaningless until qualified by the control state above
  always_ff @(posedge clk) begin
    hi_q    <= hi_d;
    idx_p_q <= idx_p_d;
    if (mem_we) begin
      mem_q[wptr_q] <= {hi_q, bus.wr_byte};
    end
  end

endmodule

// File: tb/tb_cu_program_sequencer.sv
// Bench for cu_program_sequencer: an IDLE-control vector table, then multi-cycle run
// sequences whose issued words and tagged results are checked against a scoreboard.
module tb_cu_program_sequencer;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int RES_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;

  always #5 clk = ~clk;

  cu_program_sequencer_if #(.AW(AW)) bus ();

  cu_program_sequencer #(.DEPTH(DEPTH), .AW(AW), .RES_LAT(RES_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Compute-unit stand-in: one-cycle result derived from the instruction word
  function automatic logic [7:0] cu_f(input logic [15:0] w);
    return w[15:8] ^ {w[3:0], w[7:4]} ^ 8'h3C;
  endfunction

  logic [7:0] cu_q = 8'h00;
  always @(posedge clk) if (ena) cu_q <= cu_f(bus.instr);
  assign bus.result = cu_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Reference model of the program store
  logic [15:0] m_prog [DEPTH];
  int          m_len  = 0;
  bit          m_half = 1'b0;
  logic [7:0]  m_hi   = 8'h00;

  typedef struct {
    logic [AW-1:0] idx;
    logic [7:0]    data;
  } res_t;

  logic [15:0] q_instr [$];
  res_t        q_res   [$];
  int          done_cnt = 0;

  // Monitor: an output is consumed only when the coming edge is enabled and not in reset
  always @(negedge clk) begin
    if (rst_n && ena) begin
      if (bus.instr_valid) begin
        if (q_instr.size() == 0) fail_now("sb_instr_unexpected", 32'(bus.instr));
        else chk("sb_instr", 32'(bus.instr), 32'(q_instr.pop_front()));
      end
      if (bus.res_valid) begin
        if (q_res.size() == 0) fail_now("sb_res_unexpected", 32'(bus.res_idx));
        else begin
          res_t r;
          r = q_res.pop_front();
          chk("sb_res_idx", 32'(bus.res_idx), 32'(r.idx));
          chk("sb_res_data", 32'(bus.res_data), 32'(r.data));
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_byte  = 8'h00;
    bus.start    = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    m_len  = 0;
    m_half = 1'b0;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_byte  = b;
    if (m_len < DEPTH) begin
      if (!m_half) begin
        m_hi   = b;
        m_half = 1'b1;
      end else begin
        m_prog[m_len] = {m_hi, b};
        m_len++;
        m_half = 1'b0;
      end
    end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_start();
    res_t r;
    bus.start = 1'b1;
    for (int i = 0; i < m_len; i++) begin
      q_instr.push_back(m_prog[i]);
      r.idx  = i[AW-1:0];
      r.data = cu_f(m_prog[i]);
      q_res.push_back(r);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    bit got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_instr_left"}, 32'(q_instr.size()), 32'd0);
    chk({name, "_res_left"}, 32'(q_res.size()), 32'd0);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    bit         rst_n;
    bit         ena;
    bit         clear;
    bit         wr_valid;
    logic [7:0] wr_byte;
    bit         start;
    int         exp_len;
    bit         exp_ready;
    bit         exp_busy;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // rst_n ena clr wr byte start | len ready busy
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h34, 1'b0, 0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h56, 1'b0, 1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0};

    idle_inputs();
    for (int i = 0; i < 13; i++) begin
      rst_n        = vecs[i].rst_n;
      ena          = vecs[i].ena;
      bus.clear    = vecs[i].clear;
      bus.wr_valid = vecs[i].wr_valid;
      bus.wr_byte  = vecs[i].wr_byte;
      bus.start    = vecs[i].start;
      tick();
      rst_n = 1'b1;
      ena   = 1'b1;
      idle_inputs();
      chk($sformatf("vec%0d_prog_len", i), 32'(bus.prog_len), 32'(vecs[i].exp_len));
      chk($sformatf("vec%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_instr_valid", i), 32'(bus.instr_valid), 32'd0);
      chk($sformatf("vec%0d_instr", i), 32'(bus.instr), 32'd0);
    end
    m_len  = 0;
    m_half = 1'b0;

    // Three-word program, back-to-back issue
    load_byte(8'h12); load_byte(8'h05);
    load_byte(8'h13); load_byte(8'h07);
    load_byte(8'h20); load_byte(8'h01);
    chk("a_prog_len", 32'(bus.prog_len), 32'd3);
    do_start();
    chk("a_instr0", 32'(bus.instr), 32'h1205);
    chk("a_valid0", 32'(bus.instr_valid), 32'd1);
    chk("a_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("a_instr1", 32'(bus.instr), 32'h1307);
    tick();
    chk("a_instr2", 32'(bus.instr), 32'h2001);
    tick();
    chk("a_drain_valid", 32'(bus.instr_valid), 32'd0);
    chk("a_drain_instr", 32'(bus.instr), 32'd0);
    wait_done("a");
    chk("a_done_count", 32'(done_cnt), 32'd1);
    chk("a_prog_len_kept", 32'(bus.prog_len), 32'd3);

    // Full store: 33 bytes offered, only 32 accepted
    do_clear();
    for (int i = 0; i < 32; i++) load_byte(8'(i * 7 + 3));
    chk("b_wr_ready_full", 32'(bus.wr_ready), 32'd0);
    chk("b_prog_len_full", 32'(bus.prog_len), 32'd16);
    load_byte(8'hEE);
    chk("b_prog_len_33rd", 32'(bus.prog_len), 32'd16);
    do_start();
    chk("b_busy", 32'(bus.busy), 32'd1);
    wait_done("b");
    chk("b_done_count", 32'(done_cnt), 32'd2);

    // Enable freeze in the middle of issue
    do_clear();
    for (int i = 0; i < 10; i++) load_byte(8'(8'hA0 + i * 13));
    do_start();
    chk("c_instr0", 32'(bus.instr), 32'(m_prog[0]));
    tick();
    tick();
    chk("c_instr2", 32'(bus.instr), 32'(m_prog[2]));
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("c_frozen_instr%0d", i), 32'(bus.instr), 32'(m_prog[2]));
      chk($sformatf("c_frozen_valid%0d", i), 32'(bus.instr_valid), 32'd1);
    end
    ena = 1'b1;
    tick();
    chk("c_instr3", 32'(bus.instr), 32'(m_prog[3]));
    wait_done("c");
    chk("c_done_count", 32'(done_cnt), 32'd3);

    // Re-run the retained program, then reset mid-issue
    do_start();
    chk("d_rerun_busy", 32'(bus.busy), 32'd1);
    chk("d_rerun_instr0", 32'(bus.instr), 32'(m_prog[0]));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q_instr.delete();
    q_res.delete();
    m_len  = 0;
    m_half = 1'b0;
    d0 = done_cnt;
    chk("d_busy", 32'(bus.busy), 32'd0);
    chk("d_instr", 32'(bus.instr), 32'd0);
    chk("d_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("d_prog_len", 32'(bus.prog_len), 32'd0);
    chk("d_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("d_res_valid", 32'(bus.res_valid), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("d_no_done", 32'(done_cnt), 32'(d0));
    chk("d_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
